if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS. It holds the program counter (PC) and computes PC+4. It selects the next PC from the sequential, branch, jump and jump-register sources.
- It drives the instruction-memory address and captures the returned instruction into the IF/ID pipeline register for the decode stage.
- It also supports stall, flush and a retired-fetch counter.
- Instruction memory is combinational-read: imem_rdata is valid in the same cycle as imem_addr.

Parameters:
- WIDTH, 32, data/address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- stall  in  1  hazard-unit stall; holds PC and IF/ID.
- flush  in  1  squashes IF/ID contents (taken branch or jump resolved in decode).
- pcsrc  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr.
- branch_target  in  WIDTH  branch target from decode.
- jump_target  in  WIDTH  jump target from decode.
- jr_target  in  WIDTH  register value for jr.
- imem_addr  out  WIDTH  instruction-memory address (equals pc_f).
- imem_rdata  in  WIDTH  instruction word from memory.
- pc_f  out  WIDTH  current fetch PC.
- instr_d  out  WIDTH  IF/ID instruction.
- pcplus4_d  out  WIDTH  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.
- misalign  out  1  sticky flag: a redirect target had bits[1:0] != 0.
- fetch_count  out  CNT_W  number of instructions accepted into IF/ID.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - pc_f = RESET_PC.
  - instr_d = 0, pcplus4_d = 0, valid_d = 0, misalign = 0, fetch_count = 0.
- Release of reset: the first fetch occurs at the first rising edge with rst=1. imem_addr = RESET_PC during that cycle.
- pcplus4_f = pc_f + 4, modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0.
- Next-PC mux, combinational:
  - 00 -> pcplus4_f
  - 01 -> branch_target
  - 10 -> jump_target
  - 11 -> jr_target
  - Selected target bits[1:0] are forced to 00 before loading.
- PC update on each rising edge:
  - pcsrc != 00: PC loads the selected target regardless of stall. A redirect has priority over stall.
  - pcsrc == 00 and stall=1: PC holds.
  - Otherwise: PC <= pcplus4_f.
- IF/ID update on each rising edge, in priority order:
  1. flush=1: valid_d <= 0, instr_d <= 0, pcplus4_d <= 0. Flush beats stall.
  2. stall=1: instr_d, pcplus4_d and valid_d hold.
  3. Otherwise: instr_d <= imem_rdata, pcplus4_d <= pcplus4_f, valid_d <= 1.
- fetch_count:
  - Increments by 1 exactly when case 3 occurs.
  - Wraps from 2^CNT_W-1 to 0 with no saturation.
- misalign:
  - Set at the edge where pcsrc != 00 and the unmasked target has bits[1:0] != 0.
  - Cleared only by reset.
- Latency: an instruction at address A appears on instr_d one edge after pc_f = A, absent stall and flush.
- Flush and redirect on the same edge: the IF/ID bubble is inserted and PC loads the target. The next cycle fetches the target.
- Reset asserted mid-operation: all state returns immediately to reset values. The in-flight instruction is discarded.
- X on pcsrc while rst=1 is a bench error. The RTL need not define behaviour for it.

Decomposition:
- Package mips_pkg:
  - pcsrc_t enum: PC_SEQ=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11.
  - Constant INSTR_BYTES = 4.
  - Constant NOP_INSTR = 32'h0000_0000.
- Sub-module flopenr:
  - Parameterised WIDTH register with asynchronous active-low reset, reset value, synchronous enable and synchronous clear.
  - Instantiated for the PC register and for the IF/ID instr/pcplus4/valid fields.
- The next-PC mux and counter stay inline.

Test Plan:
- Reset then free-run, imem_rdata = addr ^ 32'hA5A5_0000, no stall/flush:
  - pc_f steps 0, 4, 8, 0xC.
  - instr_d lags by one cycle.
  - valid_d=1 from the 1st edge; fetch_count=4 after 4 edges.
- stall=1 for 2 cycles at pc_f=8:
  - pc_f stays 8 and instr_d/pcplus4_d hold (pcplus4_d = 8).
  - fetch_count does not change.
  - Resume yields pc_f=0xC.
- pcsrc=01, branch_target=0x40, flush=1 at pc_f=0x10:
  - Next edge: pc_f=0x40, valid_d=0, instr_d=0.
  - Following edge: instr_d = rdata(0x40), pcplus4_d=0x44.
- pcsrc=11, jr_target=0x103, stall=1 simultaneously:
  - pc_f=0x100, misalign=1 and stays 1.
  - IF/ID holds.
- rst driven low between clock edges at pc_f=0x20:
  - pc_f=0, valid_d=0, fetch_count=0 immediately, without waiting for a clock edge.
- CNT_W=4, 17 unstalled fetches: fetch_count = 1 (wrap). Separately, preload pc_f=0xFFFF_FFFC via jump: next sequential pc_f = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_pkg;

  // Next-PC source select driven by decode.
  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pcsrc_t;

  // Size of one instruction in bytes; the sequential PC step.
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Encoding loaded into IF/ID when it is empty or squashed (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/flopenr.sv
// Register with asynchronous active-low reset, synchronous clear and
// synchronous enable. Clear wins over enable and loads RESET_VAL.
module flopenr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Reset/clear to RESET_VAL, otherwise load when enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_clr) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline
// register, sticky misaligned-redirect flag and retired-fetch counter.
//
// Flow control: valid_d qualifies instr_d/pcplus4_d towards decode. stall
// acts as "decode not ready": while it is high and no redirect is requested
// the PC and IF/ID hold. A redirect (pcsrc != 00) always moves the PC, and
// flush always empties IF/ID; an instruction is accepted (and counted) only
// on an edge with stall=0 and flush=0.
module if_stage
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pcplus4_d,
  output logic             valid_d,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_count
);

  pcsrc_t           w_pcsrc;
  logic [WIDTH-1:0] w_pc;
  logic [WIDTH-1:0] w_pcplus4_f;
  logic [WIDTH-1:0] w_target_raw;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_redirect;
  logic             w_pc_en;
  logic             w_accept;
  logic [0:0]       w_valid_q;

  logic             r_misalign;
  logic [CNT_W-1:0] r_fetch_count;

  assign w_pcsrc     = pcsrc_t'(pcsrc);
  assign w_pcplus4_f = w_pc + WIDTH'(INSTR_BYTES);
  assign w_redirect  = (w_pcsrc != PC_SEQ);
  assign w_accept    = !flush && !stall;

  // Unmasked next-PC candidate chosen by pcsrc.
  always_comb begin
    w_target_raw = w_pcplus4_f;
    case (w_pcsrc)
      PC_SEQ:  w_target_raw = w_pcplus4_f;
      PC_BR:   w_target_raw = branch_target;
      PC_J:    w_target_raw = jump_target;
      PC_JR:   w_target_raw = jr_target;
      default: w_target_raw = w_pcplus4_f;
    endcase
  end

  // Redirect targets are word-aligned before loading; a redirect overrides stall.
  assign w_pc_next = {w_target_raw[WIDTH-1:2], 2'b00};
  assign w_pc_en   = w_redirect || !stall;

  flopenr #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_pc_en),
    .i_clr   (1'b0),
    .i_d     (w_pc_next),
    .o_q     (w_pc)
  );

  // IF/ID fields: flush squashes to empty, stall holds, otherwise capture.
  flopenr #(.WIDTH(WIDTH), .RESET_VAL(WIDTH'(NOP_INSTR))) u_instr_d (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (!stall),
    .i_clr   (flush),
    .i_d     (imem_rdata),
    .o_q     (instr_d)
  );

  flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_pcplus4_d (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (!stall),
    .i_clr   (flush),
    .i_d     (w_pcplus4_f),
    .o_q     (pcplus4_d)
  );

  flopenr #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid_d (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (!stall),
    .i_clr   (flush),
    .i_d     (1'b1),
    .o_q     (w_valid_q)
  );

  // Sticky flag: any redirect whose raw target is not word-aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (w_redirect && (w_target_raw[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  // Count instructions accepted into IF/ID; wraps freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_count <= '0;
    end else if (w_accept) begin
      r_fetch_count <= r_fetch_count + 1'b1;
    end
  end

  assign pc_f        = w_pc;
  assign imem_addr   = w_pc;
  assign valid_d     = w_valid_q[0];
  assign misalign    = r_misalign;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, with a
// behavioural fetch model feeding an expected queue and a monitor that
// compares every post-edge snapshot. A second instance with CNT_W=4 shares
// the stimulus to exercise counter wrap.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [1:0]  pcsrc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        misalign;
  logic [15:0] fetch_count;

  logic [31:0] imem_addr4;
  logic [31:0] pc_f4;
  logic [31:0] instr_d4;
  logic [31:0] pcplus4_d4;
  logic        valid_d4;
  logic        misalign4;
  logic [3:0]  fetch_count4;

  int checks = 0;
  int errors = 0;

  // Instruction memory contents are a fixed function of the address.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pcsrc(pcsrc),
    .branch_target(branch_target), .jump_target(jump_target),
    .jr_target(jr_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_f(pc_f), .instr_d(instr_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .misalign(misalign), .fetch_count(fetch_count)
  );

  if_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pcsrc(pcsrc),
    .branch_target(branch_target), .jump_target(jump_target),
    .jr_target(jr_target), .imem_addr(imem_addr4), .imem_rdata(imem_rdata),
    .pc_f(pc_f4), .instr_d(instr_d4), .pcplus4_d(pcplus4_d4),
    .valid_d(valid_d4), .misalign(misalign4), .fetch_count(fetch_count4)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_mis;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0;
    m_valid = 1'b0; m_mis = 1'b0; m_cnt = 16'h0;
  endtask

  // Drive one cycle's inputs (called while clk is low), predict the state
  // after the coming rising edge, then advance to the next falling edge.
  task automatic cycle(input logic [1:0] src, input logic [31:0] tgt,
                       input logic st, input logic fl);
    logic [31:0] seq, npc;
    exp_t e;
    pcsrc = src; stall = st; flush = fl;
    branch_target = (src == 2'b01) ? tgt : $urandom;
    jump_target   = (src == 2'b10) ? tgt : $urandom;
    jr_target     = (src == 2'b11) ? tgt : $urandom;
    seq = m_pc + 32'd4;
    if (src != 2'b00) begin
      npc = tgt & 32'hFFFF_FFFC;
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
    end else if (st) begin
      npc = m_pc;
    end else begin
      npc = seq;
    end
    if (fl) begin
      m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = m_pc ^ 32'hA5A5_0000; m_pp4 = seq; m_valid = 1'b1;
      m_cnt = m_cnt + 16'd1;
    end
    m_pc = npc;
    e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4;
    e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 32'h0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_f",         pc_f,                 e.pc);
      chk("instr_d",      instr_d,              e.instr);
      chk("pcplus4_d",    pcplus4_d,            e.pp4);
      chk("valid_d",      {31'h0, valid_d},     {31'h0, e.valid});
      chk("misalign",     {31'h0, misalign},    {31'h0, e.mis});
      chk("fetch_count",  {16'h0, fetch_count}, {16'h0, e.cnt});
      chk("fetch_count4", {28'h0, fetch_count4}, {28'h0, e.cnt[3:0]});
      chk("pc_f_cnt4",    pc_f4,                e.pc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] src;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; pcsrc = 2'b00;
    branch_target = '0; jump_target = '0; jr_target = '0;
    model_reset();

    // Reset values without any clock edge.
    #2;
    chk("rst_pc_f",        pc_f,                 32'h0);
    chk("rst_imem_addr",   imem_addr,            32'h0);
    chk("rst_instr_d",     instr_d,              32'h0);
    chk("rst_pcplus4_d",   pcplus4_d,            32'h0);
    chk("rst_valid_d",     {31'h0, valid_d},     32'h0);
    chk("rst_misalign",    {31'h0, misalign},    32'h0);
    chk("rst_fetch_count", {16'h0, fetch_count}, 32'h0);
    #1 rst = 1'b1;

    // Free run: 0,4,8; then stall two cycles at pc_f=8; resume.
    run_free(2);
    cycle(2'b00, 32'h0, 1'b1, 1'b0);
    cycle(2'b00, 32'h0, 1'b1, 1'b0);
    chk("stall_pcplus4_hold", pcplus4_d, 32'h8);
    run_free(2);
    chk("free_fetch_count", {16'h0, fetch_count}, 32'h4);

    // Branch to 0x40 with flush at pc_f=0x10.
    cycle(2'b01, 32'h40, 1'b0, 1'b1);
    chk("flush_valid", {31'h0, valid_d}, 32'h0);
    run_free(2);

    // Misaligned jr with simultaneous stall.
    cycle(2'b11, 32'h103, 1'b1, 1'b0);
    chk("jr_pc_aligned", pc_f, 32'h100);
    run_free(3);
    chk("misalign_sticky", {31'h0, misalign}, 32'h1);

    // Jump near 0x20, then assert reset between edges.
    cycle(2'b10, 32'h1C, 1'b0, 1'b0);
    run_free(1);
    #2 rst = 1'b0;
    #1;
    chk("async_pc_f",        pc_f,                  32'h0);
    chk("async_valid_d",     {31'h0, valid_d},      32'h0);
    chk("async_fetch_count", {16'h0, fetch_count},  32'h0);
    chk("async_misalign",    {31'h0, misalign},     32'h0);
    chk("async_instr_d",     instr_d,               32'h0);
    model_reset();
    #1 rst = 1'b1;

    // 17 unstalled fetches wrap the 4-bit counter to 1.
    run_free(17);
    chk("cnt4_wrap", {28'h0, fetch_count4}, 32'h1);

    // PC wrap from the top of the address space.
    cycle(2'b10, 32'hFFFF_FFFC, 1'b0, 1'b0);
    run_free(1);
    chk("pc_wrap", pc_f, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      src = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      cycle(src, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
